program_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 18 +
 rtl/byte_word_assembler.sv | 49 ++++
 rtl/program_loader.sv | 118 +++++++++++
 tb/tb_program_loader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the program loader
// Contents:
//   loader_state_t   : loader FSM states
//   HALT_INSTRUCTION : word that ends a program (also written to memory)
//   BYTES_PER_WORD   : bytes assembled into one instruction word
package loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } loader_state_t;

   localparam logic [31:0] HALT_INSTRUCTION = 32'h0000_0000;
   localparam int          BYTES_PER_WORD   = 4;

endpackage

// File: rtl/byte_word_assembler.sv
// rtl/byte_word_assembler.sv - little-endian byte to 32-bit word assembler
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   byte_valid   : a byte is accepted this cycle
//   byte_data    : the accepted byte
//   clear        : restart assembly at lane 0 with an empty register
//   word         : assembly register with the current byte merged in
//   word_ready   : pulse, the byte accepted this cycle completes a word
module byte_word_assembler
   import loader_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   input  logic        clear,
   output logic [31:0] word,
   output logic        word_ready
);

   localparam int                LANE_W    = $clog2(BYTES_PER_WORD);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

   logic [LANE_W-1:0] lane;
   logic [31:0]       word_reg;

   // The completed word is visible in the same cycle as its last byte so the
   // loader can register it straight into the memory write data.
   always_comb begin
      word = word_reg;
      word[lane*8 +: 8] = byte_data;
   end

   assign word_ready = byte_valid && (lane == LAST_LANE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lane     <= '0;
         word_reg <= '0;
      end else if (clear) begin
         lane     <= '0;
         word_reg <= '0;
      end else if (byte_valid) begin
         word_reg <= word;
         lane     <= lane + LANE_W'(1);
      end
   end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program loader for instruction memory
// Ports:
//   clock, reset      : system clock, asynchronous active-high reset
//   start             : pulse, begins a load from IDLE or DONE
//   in_valid, in_data : incoming byte stream (little-endian words)
//   in_ready          : byte stream ready, high only while loading
//   mem_write_enable  : one-cycle instruction memory write strobe
//   mem_address       : byte address of the write
//   mem_write_data    : assembled instruction word
//   cpu_reset         : holds the processor in reset except in DONE
//   done              : load complete
//   overflow          : memory filled before a halt word arrived
//   word_count        : words written by the last or current load
module program_loader
   import loader_pkg::*;
#(
   parameter int          ADDRESS_WIDTH = 8,
   parameter logic [31:0] BASE_ADDRESS  = 32'h0000_0000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   in_valid,
   input  logic [7:0]             in_data,
   output logic                   in_ready,
   output logic                   mem_write_enable,
   output logic [31:0]            mem_address,
   output logic [31:0]            mem_write_data,
   output logic                   cpu_reset,
   output logic                   done,
   output logic                   overflow,
   output logic [ADDRESS_WIDTH:0] word_count
);

   localparam logic [ADDRESS_WIDTH-1:0] LAST_INDEX = {ADDRESS_WIDTH{1'b1}};
   localparam logic [ADDRESS_WIDTH-1:0] INDEX_ONE  = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDRESS_WIDTH:0]   COUNT_ONE  = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

   loader_state_t           state;
   logic [ADDRESS_WIDTH-1:0] word_index;
   logic [31:0]              index_ext;
   logic                     byte_accept;
   logic                     begin_load;
   logic                     asm_clear;
   logic [31:0]              asm_word;
   logic                     asm_word_ready;

   assign in_ready    = (state == LOAD);
   assign byte_accept = in_valid && in_ready;
   assign begin_load  = start && ((state == IDLE) || (state == DONE));
   assign asm_clear   = begin_load || (state == WRITE);
   assign index_ext   = 32'(word_index);

   byte_word_assembler u_assembler (
      .clock      (clock),
      .reset      (reset),
      .byte_valid (byte_accept),
      .byte_data  (in_data),
      .clear      (asm_clear),
      .word       (asm_word),
      .word_ready (asm_word_ready)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         cpu_reset        <= 1'b1;
         mem_write_enable <= 1'b0;
         mem_address      <= '0;
         mem_write_data   <= '0;
         done             <= 1'b0;
         overflow         <= 1'b0;
         word_count       <= '0;
         word_index       <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (begin_load) begin
                  state      <= LOAD;
                  cpu_reset  <= 1'b1;
                  done       <= 1'b0;
                  overflow   <= 1'b0;
                  word_index <= '0;
                  word_count <= '0;
               end
            end
            LOAD: begin
               if (asm_word_ready) begin
                  state            <= WRITE;
                  mem_write_enable <= 1'b1;
                  mem_address      <= BASE_ADDRESS + (index_ext << 2);
                  mem_write_data   <= asm_word;
               end
            end
            WRITE: begin
               mem_write_enable <= 1'b0;
               word_count       <= word_count + COUNT_ONE;
               // A halt in the last location is a clean finish, not overflow.
               if (mem_write_data == HALT_INSTRUCTION) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  cpu_reset <= 1'b0;
               end else if (word_index == LAST_INDEX) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  overflow  <= 1'b1;
                  cpu_reset <= 1'b0;
               end else begin
                  state      <= LOAD;
                  word_index <= word_index + INDEX_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader
// Ports: none (two DUT instances, depth 256 and depth 4, share clock/reset)
module tb_program_loader;

   typedef logic [7:0] byte_q_t[$];

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        sel;

   logic        a_ready, a_we, a_cpu_reset, a_done, a_ovf;
   logic [31:0] a_addr, a_data;
   logic [8:0]  a_count;
   logic        b_ready, b_we, b_cpu_reset, b_done, b_ovf;
   logic [31:0] b_addr, b_data;
   logic [2:0]  b_count;

   logic        cur_ready, cur_we, cur_cpu_reset, cur_done, cur_ovf;
   logic [31:0] cur_addr, cur_data;
   logic [8:0]  cur_count;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   program_loader #(.ADDRESS_WIDTH(8), .BASE_ADDRESS(32'h0)) dut_a (
      .clock(clock), .reset(reset), .start(start && !sel),
      .in_valid(in_valid && !sel), .in_data(in_data), .in_ready(a_ready),
      .mem_write_enable(a_we), .mem_address(a_addr), .mem_write_data(a_data),
      .cpu_reset(a_cpu_reset), .done(a_done), .overflow(a_ovf),
      .word_count(a_count)
   );

   program_loader #(.ADDRESS_WIDTH(2), .BASE_ADDRESS(32'h0)) dut_b (
      .clock(clock), .reset(reset), .start(start && sel),
      .in_valid(in_valid && sel), .in_data(in_data), .in_ready(b_ready),
      .mem_write_enable(b_we), .mem_address(b_addr), .mem_write_data(b_data),
      .cpu_reset(b_cpu_reset), .done(b_done), .overflow(b_ovf),
      .word_count(b_count)
   );

   assign cur_ready     = sel ? b_ready     : a_ready;
   assign cur_we        = sel ? b_we        : a_we;
   assign cur_cpu_reset = sel ? b_cpu_reset : a_cpu_reset;
   assign cur_done      = sel ? b_done      : a_done;
   assign cur_ovf       = sel ? b_ovf       : a_ovf;
   assign cur_addr      = sel ? b_addr      : a_addr;
   assign cur_data      = sel ? b_data      : a_data;
   assign cur_count     = sel ? {6'd0, b_count} : a_count;

   // Write monitor: records every strobe and whether it came exactly one
   // cycle after the most recent accepted byte.
   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];
   int          ncyc = 0;
   int          last_acc = -10;
   int          lat_bad = 0;

   always @(negedge clock) begin
      ncyc = ncyc + 1;
      if (cur_we === 1'b1) begin
         wa_q.push_back(cur_addr);
         wd_q.push_back(cur_data);
         if (ncyc != last_acc + 1) lat_bad = lat_bad + 1;
      end
      if (in_valid && cur_ready) last_acc = ncyc;
   end

   // Reference model: expected writes derived from the byte stream alone.
   logic [31:0] exp_a[$];
   logic [31:0] exp_d[$];
   logic        exp_ovf;

   function automatic void model(input byte_q_t b, input int depth);
      logic [31:0] w;
      exp_a.delete();
      exp_d.delete();
      exp_ovf = 1'b0;
      for (int i = 0; i * 4 + 3 < b.size(); i++) begin
         w = {b[i*4+3], b[i*4+2], b[i*4+1], b[i*4]};
         exp_a.push_back(32'(i * 4));
         exp_d.push_back(w);
         if (w == 32'h0) break;
         if (i == depth - 1) begin
            exp_ovf = 1'b1;
            break;
         end
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input string tag);
      logic r;
      logic ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         r = cur_ready;
         @(posedge clock);
         #1;
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
      check({tag, "_byte_accepted"}, {31'd0, ok}, 32'd1);
   endtask

   task automatic make_prog(input int nw, input logic halt_last, output byte_q_t q);
      logic [31:0] w;
      q.delete();
      for (int i = 0; i < nw; i++) begin
         if (halt_last && i == nw - 1) w = 32'h0;
         else begin
            w = $urandom;
            if (w == 32'h0) w = 32'h1;
         end
         q.push_back(w[7:0]);
         q.push_back(w[15:8]);
         q.push_back(w[23:16]);
         q.push_back(w[31:24]);
      end
   endtask

   task automatic run_load(input logic s, input byte_q_t b, input int depth,
                           input int max_gap, input int start_at, input string tag);
      int n;
      model(b, depth);
      n = exp_d.size() * 4;
      sel = s;
      wa_q.delete();
      wd_q.delete();
      lat_bad = 0;
      pulse_start();
      check({tag, "_start_cpu_reset"}, {31'd0, cur_cpu_reset}, 32'd1);
      check({tag, "_start_done"}, {31'd0, cur_done}, 32'd0);
      for (int i = 0; i < n; i++) begin
         if (i == start_at) pulse_start();
         if (max_gap > 0) idle_cycles(int'($urandom_range(max_gap, 0)));
         send_byte(b[i], tag);
      end
      @(negedge clock);
      check({tag, "_last_strobe"}, {31'd0, cur_we}, 32'd1);
      check({tag, "_cpu_reset_at_write"}, {31'd0, cur_cpu_reset}, 32'd1);
      @(negedge clock);
      check({tag, "_done"}, {31'd0, cur_done}, 32'd1);
      check({tag, "_cpu_reset_released"}, {31'd0, cur_cpu_reset}, 32'd0);
      check({tag, "_in_ready_low"}, {31'd0, cur_ready}, 32'd0);
      check({tag, "_overflow"}, {31'd0, cur_ovf}, {31'd0, exp_ovf});
      check({tag, "_word_count"}, {23'd0, cur_count}, 32'(exp_d.size()));
      check({tag, "_num_writes"}, 32'(wa_q.size()), 32'(exp_d.size()));
      for (int i = 0; i < exp_d.size() && i < wa_q.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), wa_q[i], exp_a[i]);
         check($sformatf("%s_data%0d", tag, i), wd_q[i], exp_d[i]);
      end
      check({tag, "_strobe_latency"}, 32'(lat_bad), 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_we"}, {31'd0, cur_we}, 32'd0);
      check({tag, "_addr"}, cur_addr, 32'd0);
      check({tag, "_data"}, cur_data, 32'd0);
      check({tag, "_count"}, {23'd0, cur_count}, 32'd0);
      check({tag, "_done"}, {31'd0, cur_done}, 32'd0);
      check({tag, "_ovf"}, {31'd0, cur_ovf}, 32'd0);
      check({tag, "_cpu_reset"}, {31'd0, cur_cpu_reset}, 32'd1);
      check({tag, "_in_ready"}, {31'd0, cur_ready}, 32'd0);
   endtask

   byte_q_t p1;
   byte_q_t p;

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      sel      = 1'b0;
      #1;
      check_reset_values("por_a");
      sel = 1'b1;
      #1;
      check_reset_values("por_b");
      sel = 1'b0;
      idle_cycles(2);
      reset = 1'b0;
      idle_cycles(2);

      // Three-word program ending in a halt, no gaps then random gaps.
      p1 = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00};
      run_load(1'b0, p1, 256, 0, -1, "s1");
      check("s1_word0_literal", wd_q[0], 32'h0050_0093);
      check("s1_word1_literal", wd_q[1], 32'h0010_0113);
      idle_cycles(2);
      run_load(1'b0, p1, 256, 3, -1, "s2");
      idle_cycles(2);

      // Depth-4 memory: fill without halt, then halt in the last location.
      p = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
            8'h33, 8'h33, 8'h33, 8'h33, 8'h44, 8'h44, 8'h44, 8'h44};
      run_load(1'b1, p, 4, 1, -1, "s3_ovf");
      p = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
            8'h33, 8'h33, 8'h33, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00};
      run_load(1'b1, p, 4, 0, -1, "s3_halt");
      idle_cycles(2);

      // Reset two bytes into the first word of a load started from DONE.
      sel = 1'b0;
      wa_q.delete();
      wd_q.delete();
      pulse_start();
      check("s4_start_cpu_reset", {31'd0, cur_cpu_reset}, 32'd1);
      check("s4_start_done", {31'd0, cur_done}, 32'd0);
      send_byte(8'hAA, "s4");
      send_byte(8'hBB, "s4");
      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      check_reset_values("s4_async");
      @(negedge clock);
      reset = 1'b0;
      idle_cycles(3);
      check("s4_no_strobe", 32'(wa_q.size()), 32'd0);
      p = '{8'h37, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_load(1'b0, p, 256, 1, -1, "s4_reload");
      idle_cycles(1);

      // Restart from DONE with a lone halt word.
      p = '{8'h00, 8'h00, 8'h00, 8'h00};
      run_load(1'b0, p, 256, 0, -1, "s5");

      // start pulsed after the first byte must be ignored.
      make_prog(3, 1'b1, p);
      run_load(1'b0, p, 256, 0, 1, "s6");

      // Randomized programs on both memory depths.
      for (int r = 0; r < 4; r++) begin
         int nw;
         logic h;
         nw = int'($urandom_range(6, 1));
         make_prog(nw, 1'b1, p);
         run_load(1'b0, p, 256, 2, -1, $sformatf("rnd_a%0d", r));
         nw = int'($urandom_range(6, 1));
         h  = 1'($urandom_range(1, 0));
         if (!h && nw < 4) nw = 4;
         make_prog(nw, h, p);
         run_load(1'b1, p, 4, 2, -1, $sformatf("rnd_b%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
